ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter that shares one single-port synchronous `ram` between the instruction-fetch path (I, read-only) and the load/store path (D, read/write). It is used in core configurations that cannot afford the dual-port memory. D has fixed priority, and a bounded-wait counter guarantees I forward progress. The block owns the `ram` instance, registers which requester owns the in-flight read, and returns read data with a one-cycle-latency valid strobe.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 1024, words in the RAM; address width AW = $clog2(DEPTH)
- MAX_WAIT, 3, maximum consecutive cycles a pending I request may lose to D; 0 makes I always win

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; held with i_addr until i_gnt
- i_addr  in  AW  instruction word address
- i_gnt  out  1  I request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid; registered
- i_rdata  out  WIDTH  instruction read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data word address
- d_wdata  in  WIDTH  write data
- d_gnt  out  1  D request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (reads only); registered
- d_rdata  out  WIDTH  data read data

## Operation
- At most one grant per cycle, and there is no idle turnaround: throughput is one access per cycle.
- Arbitration when both requests are pending: D wins unless `starve` is set (wait_cnt == MAX_WAIT), in which case I wins. A lone request always wins.
- wait_cnt, width $clog2(MAX_WAIT+1):
  - +1 each cycle with i_req && !i_gnt, saturating at MAX_WAIT.
  - Cleared on i_gnt or !i_req.
- RAM drive:
  - addr = granted requester's address (d_addr when nothing is granted).
  - write_en = d_gnt && d_we.
  - data_i = d_wdata.
- Owner register `own` has states OWN_NONE, OWN_I, OWN_D. It loads next-cycle owner as follows:
  - i_gnt → OWN_I
  - d_gnt && !d_we → OWN_D
  - else → OWN_NONE
- Response: i_rvalid = (own == OWN_I), d_rvalid = (own == OWN_D). Both rdata outputs are wired to the RAM's data_o. The consumer must ignore rdata while the matching rvalid is 0.
- Writes produce no response; d_gnt is the write acknowledgement.
- Reset (reset_n low, asynchronous):
  - own = OWN_NONE, wait_cnt = 0.
  - i_gnt = d_gnt = 0 and RAM write_en = 0 (gated combinationally by reset_n).
  - i_rvalid = d_rvalid = 0.
  - RAM contents are not cleared.
- Reset mid-operation: any in-flight read response is dropped (its rvalid never asserts). Requesters must re-issue after reset.

## Timing
- Cycle N: request is present and the grant is asserted in the same cycle. The RAM samples addr/write_en at the rising edge ending N.
- Cycle N+1: the matching rvalid is high and rdata is valid. Read latency is exactly 1 cycle.
- Back-to-back grants to the same requester produce back-to-back rvalid cycles.
- D write at cycle N followed by any read of the same address at N+1 or later returns the new data.
- Same-cycle I read and D write to the same address, D granted: the I read is served at N+1 or later and returns the written data.
- Starvation bound: a continuously asserted i_req is granted within MAX_WAIT+1 cycles, even under continuous d_req.
- A requester must not change address/data while its req is high and its gnt is low. Behaviour is undefined if it does.

## Structure
- Package `ram_arb_pkg` holds:
  - the `own_t` enum (OWN_NONE, OWN_I, OWN_D);
  - function `clog2_min1` so that wait_cnt width is ≥ 1 when MAX_WAIT = 0.
- One sub-module: the existing single-port `ram`, instantiated with WIDTH and DEPTH.
- Arbitration, wait counter and owner register are flat in this module. No further sub-modules.

## Test plan
- Lone I reads at addresses 0..3, preloaded with 0x11..0x44 → i_gnt each cycle; i_rvalid at N+1..N+4 with 0x11, 0x22, 0x33, 0x44; d_rvalid stays 0.
- D write 0xDEADBEEF to address 5 at cycle N, D read of address 5 at N+1 → d_gnt both cycles, no d_rvalid at N+1, d_rvalid with 0xDEADBEEF at N+2.
- MAX_WAIT=3, continuous D reads with i_req held from cycle 0 → D granted cycles 0–2, I granted cycle 3, D resumes at cycle 4; wait_cnt returns to 0.
- Same cycle: I read of address 7 (old 0x0) and D write of 0x5A5A to address 7 → D granted first; I granted the next cycle; i_rdata = 0x5A5A.
- Drop reset_n while an I read response is pending → i_rvalid stays 0; gnts and write_en go 0 immediately. After release, RAM contents written before reset read back intact.
- MAX_WAIT=0 with both requesting continuously → I granted every cycle, D never granted.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  // $clog2 of 1 is 0; the wait counter still needs one bit when MAX_WAIT is 0.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the I and D requesters and the RAM arbiter.
interface ram_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
);
  logic             i_req;
  logic [AW-1:0]    i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [WIDTH-1:0] i_rdata;
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );
endinterface

// File: rtl/ram_arbiter_ram.sv
// Single-port synchronous RAM: one-cycle registered read, contents never reset.
module ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= data_i;
    data_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (read-only) and load/store;
// D has fixed priority, a bounded-wait counter guarantees I forward progress.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_min1(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  own_t             own_q, own_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             starve, i_win, d_win;
  logic             i_gnt, d_gnt;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata;

  assign starve = (wait_cnt_q == WAIT_MAX);

  // Grants are masked by reset_n so nothing reaches the RAM while in reset.
  always_comb begin
    i_win    = bus.i_req && (!bus.d_req || starve);
    d_win    = bus.d_req && !i_win;
    i_gnt    = reset_n && i_win;
    d_gnt    = reset_n && d_win;
    ram_addr = i_gnt ? bus.i_addr : bus.d_addr;
    ram_we   = d_gnt && bus.d_we;
  end

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      own_q      <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      own_q      <= own_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (i_gnt)                    own_d = OWN_I;
    else if (d_gnt && !bus.d_we)  own_d = OWN_D;

    wait_cnt_d = wait_cnt_q;
    if (!bus.i_req || i_gnt)      wait_cnt_d = '0;
    else if (!starve)             wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_comb begin
    bus.i_rvalid = (own_q == OWN_I);
    bus.d_rvalid = (own_q == OWN_D);
  end

  // Both requesters see the RAM output; rvalid says whose data it is.
  assign bus.i_rdata = ram_rdata;
  assign bus.d_rdata = ram_rdata;

  ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .data_i (bus.d_wdata),
    .data_o (ram_rdata)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: queued requester stimulus, a reference model
// of memory and arbitration, and a monitor that checks every response cycle.
module tb_ram_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int MW    = 3;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } item_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  ram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus0 ();

  ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(MW)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(0)) u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  item_t            istim[$], dstim[$];
  logic [WIDTH-1:0] iq[$], dq[$];
  logic [WIDTH-1:0] mdl_mem [0:31];
  int               lost = 0;
  logic             i_seen = 1'b0, d_seen = 1'b0;
  int               vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who should win this cycle, and what each read must return.
  initial begin
    logic ei, ed;
    forever begin
      @(negedge clock);
      ei = 1'b0;
      ed = 1'b0;
      if (!reset_n) begin
        lost = 0;
      end else begin
        ei = bus.i_req && (!bus.d_req || lost >= MW);
        ed = bus.d_req && !ei;
      end
      chk("i_gnt", WIDTH'(bus.i_gnt), WIDTH'(ei));
      chk("d_gnt", WIDTH'(bus.d_gnt), WIDTH'(ed));
      if (reset_n) begin
        if (ei) iq.push_back(mdl_mem[bus.i_addr[4:0]]);
        if (ed) begin
          if (bus.d_we) mdl_mem[bus.d_addr[4:0]] = bus.d_wdata;
          else          dq.push_back(mdl_mem[bus.d_addr[4:0]]);
        end
        lost = (bus.i_req && !ei) ? lost + 1 : 0;
      end
      i_seen = bus.i_gnt;
      d_seen = bus.d_gnt;
    end
  end

  // Monitor: each queued read must appear exactly one cycle after its grant.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clock);
      #2;
      if (iq.size() > 0) begin
        e = iq.pop_front();
        chk("i_rvalid", WIDTH'(bus.i_rvalid), WIDTH'(1));
        chk("i_rdata", bus.i_rdata, e);
      end else begin
        chk("i_rvalid_idle", WIDTH'(bus.i_rvalid), WIDTH'(0));
      end
      if (dq.size() > 0) begin
        e = dq.pop_front();
        chk("d_rvalid", WIDTH'(bus.d_rvalid), WIDTH'(1));
        chk("d_rdata", bus.d_rdata, e);
      end else begin
        chk("d_rvalid_idle", WIDTH'(bus.d_rvalid), WIDTH'(0));
      end
    end
  end

  task automatic push_i(input int a);
    istim.push_back('{v: 1'b1, we: 1'b0, addr: AW'(a), data: '0});
  endtask

  task automatic push_d(input logic we, input int a, input logic [WIDTH-1:0] d);
    dstim.push_back('{v: 1'b1, we: we, addr: AW'(a), data: d});
  endtask

  task automatic step();
    item_t it;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end else begin
      if (!bus.i_req || i_seen) begin
        if (istim.size() > 0) begin
          it = istim.pop_front();
          bus.i_req  = it.v;
          bus.i_addr = it.addr;
        end else bus.i_req = 1'b0;
      end
      if (!bus.d_req || d_seen) begin
        if (dstim.size() > 0) begin
          it = dstim.pop_front();
          bus.d_req   = it.v;
          bus.d_we    = it.we;
          bus.d_addr  = it.addr;
          bus.d_wdata = it.data;
        end else bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((istim.size() != 0 || dstim.size() != 0 || bus.i_req || bus.d_req) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", WIDTH'(n < budget), WIDTH'(1));
    repeat (2) step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus0.i_req = 1'b1; bus0.i_addr = '0;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = AW'(1); bus0.d_wdata = '0;

    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // Preload every address the bench touches.
    for (int a = 0; a < 32; a++) begin
      if (a < 4)       push_d(1'b1, a, WIDTH'((a + 1) * 32'h11));
      else if (a == 7) push_d(1'b1, a, '0);
      else             push_d(1'b1, a, $urandom);
    end
    drain(200);

    for (int a = 0; a < 4; a++) push_i(a);
    drain(50);

    push_d(1'b1, 5, 32'hDEADBEEF);
    push_d(1'b0, 5, '0);
    drain(50);

    // D floods reads while I waits: I must win on its fourth pending cycle.
    for (int j = 0; j < 6; j++) push_d(1'b0, j + 8, '0);
    push_i(9);
    drain(50);

    push_i(7);
    push_d(1'b1, 7, 32'h5A5A);
    drain(50);

    // Reset while an I read is in flight and a D write is still pending.
    for (int j = 0; j < 4; j++) push_d(1'b1, 20 + j, $urandom);
    push_i(2);
    k = 0;
    while (k < 20) begin
      step();
      @(negedge clock);
      #1;
      if (i_seen) break;
      k++;
    end
    chk("reset_setup", WIDTH'(k < 20), WIDTH'(1));
    reset_n = 1'b0;
    #1;
    chk("i_gnt_in_reset", WIDTH'(bus.i_gnt), WIDTH'(0));
    chk("d_gnt_in_reset", WIDTH'(bus.d_gnt), WIDTH'(0));
    chk("ram_we_in_reset", WIDTH'(u_dut.ram_we), WIDTH'(0));
    iq.delete();
    dq.delete();
    @(posedge clock);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;

    for (int a = 0; a < 4; a++) push_i(a);
    push_d(1'b0, 5, '0);
    push_d(1'b0, 20, '0);
    drain(50);

    for (int j = 0; j < 200; j++) begin
      istim.push_back('{v: ($urandom_range(0, 3) != 0), we: 1'b0,
                        addr: AW'($urandom_range(0, 31)), data: '0});
      dstim.push_back('{v: ($urandom_range(0, 3) != 0), we: 1'($urandom_range(0, 1)),
                        addr: AW'($urandom_range(0, 31)), data: $urandom});
    end
    drain(3000);

    // MAX_WAIT=0 instance has had both requests high since reset release.
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      #1;
      chk("mw0_i_gnt", WIDTH'(bus0.i_gnt), WIDTH'(1));
      chk("mw0_d_gnt", WIDTH'(bus0.d_gnt), WIDTH'(0));
      chk("mw0_i_rvalid", WIDTH'(bus0.i_rvalid), WIDTH'(1));
      chk("mw0_d_rvalid", WIDTH'(bus0.d_rvalid), WIDTH'(0));
    end

    chk("iq_empty", WIDTH'(iq.size()), WIDTH'(0));
    chk("dq_empty", WIDTH'(dq.size()), WIDTH'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
